// File: rtl/handshake_fifo.sv
// Parametrised valid/ready FIFO placed inline on a handshake link.
// Define HANDSHAKE_FIFO_STATS_EN to build the beats_out / max_count statistics.
module handshake_fifo #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 4,
    parameter int AF_LEVEL  = DEPTH - 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [DATA_BITS-1:0]         s_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DATA_BITS-1:0]         m_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         almost_full,
    output logic [31:0]                  beats_out,
    output logic [$clog2(DEPTH+1)-1:0]   max_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [PW-1:0]        wp;
    logic [PW-1:0]        rp;
    logic                 push;
    logic                 pop;

    // A beat moves on a side only in a cycle where valid and ready are both
    // high at the rising edge; valid never waits on ready, and s_ready never
    // looks at m_ready, so a full FIFO reopens one cycle after a pop.
    assign s_ready     = rst && (count != FULL_CNT);
    assign m_valid     = (count != '0);
    assign push        = s_valid && s_ready;
    assign pop         = m_valid && m_ready;
    assign m_data      = mem[rp];
    assign almost_full = (count >= AF_CNT);

    // Storage is intentionally not reset; contents are don't-care when empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wp <= wp + PTR_ONE;
            end
            if (pop) begin
                rp <= rp + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

`ifdef HANDSHAKE_FIFO_STATS_EN
    // High-water mark follows the registered occupancy, one cycle behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beats_out <= '0;
            max_count <= '0;
        end else begin
            if (pop) begin
                beats_out <= beats_out + 32'd1;
            end
            if (count > max_count) begin
                max_count <= count;
            end
        end
    end
`else
    assign beats_out = '0;
    assign max_count = '0;
`endif

endmodule

// File: tb/tb_handshake_fifo.sv
// Directed bench for handshake_fifo (DATA_BITS=8, DEPTH=4, AF_LEVEL=3).
// Statistics expectations follow whether HANDSHAKE_FIFO_STATS_EN is defined.
module tb_handshake_fifo;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic [2:0]  count;
    logic        almost_full;
    logic [31:0] beats_out;
    logic [2:0]  max_count;

    int          checks = 0;
    int          errors = 0;
    int          peak   = 0;
    logic [7:0]  exp_q[$];

    handshake_fifo #(
        .DATA_BITS (8),
        .DEPTH     (4),
        .AF_LEVEL  (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .count       (count),
        .almost_full (almost_full),
        .beats_out   (beats_out),
        .max_count   (max_count)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; the scoreboard samples the handshake at the falling edge.
    task automatic step(input logic sv, input logic [7:0] sd, input logic mr);
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        @(negedge clk);
        if (int'(count) > peak) peak = int'(count);
        if (m_valid && m_ready) begin
            check("pop_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("pop_order", 32'(m_data), 32'(exp_q.pop_front()));
        end
        if (s_valid && s_ready) exp_q.push_back(s_data);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_beats_out", beats_out, 32'd0);
        check("rst_max_count", 32'(max_count), 32'd0);
        rst = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] d;
        rst     = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h00;
        m_ready = 1'b0;

        // reset held with upstream asserting valid
        repeat (10) @(posedge clk);
        #1;
        check("reset_s_ready", 32'(s_ready), 32'd0);
        check("reset_m_valid", 32'(m_valid), 32'd0);
        check("reset_count", 32'(count), 32'd0);
        check("reset_almost_full", 32'(almost_full), 32'd0);
        check("reset_beats_out", beats_out, 32'd0);
        check("reset_max_count", 32'(max_count), 32'd0);
        s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("release_s_ready", 32'(s_ready), 32'd1);
        check("release_count", 32'(count), 32'd0);

        // always-ready slave: two separate beats
        peak = 0;
        step(1'b1, 8'hA5, 1'b1);
        check("a5_m_valid", 32'(m_valid), 32'd1);
        check("a5_m_data", 32'(m_data), 32'hA5);
        check("a5_count", 32'(count), 32'd1);
        step(1'b0, 8'h00, 1'b1);
        check("a5_drained", 32'(m_valid), 32'd0);
        step(1'b1, 8'hC4, 1'b1);
        check("c4_m_data", 32'(m_data), 32'hC4);
        step(1'b0, 8'h00, 1'b1);
        check("c4_drained_count", 32'(count), 32'd0);
        check("ready_peak", 32'(peak), 32'd1);

        // fill with downstream stalled; 0x05 held while full
        step(1'b1, 8'h01, 1'b0);
        check("fill1_af", 32'(almost_full), 32'd0);
        step(1'b1, 8'h02, 1'b0);
        check("fill2_af", 32'(almost_full), 32'd0);
        step(1'b1, 8'h03, 1'b0);
        check("fill3_count", 32'(count), 32'd3);
        check("fill3_af", 32'(almost_full), 32'd1);
        step(1'b1, 8'h04, 1'b0);
        check("full_count", 32'(count), 32'd4);
        check("full_s_ready", 32'(s_ready), 32'd0);
        check("full_af", 32'(almost_full), 32'd1);
        check("full_head", 32'(m_data), 32'h01);
        step(1'b1, 8'h05, 1'b0);
        check("stall_count", 32'(count), 32'd4);
        check("stall_head_stable", 32'(m_data), 32'h01);
        step(1'b1, 8'h05, 1'b1);
        check("reopen_count", 32'(count), 32'd3);
        check("reopen_s_ready", 32'(s_ready), 32'd1);
        step(1'b1, 8'h05, 1'b1);
        check("swap_count", 32'(count), 32'd3);
        repeat (3) step(1'b0, 8'h00, 1'b1);
        check("fill_drained", 32'(count), 32'd0);
        check("fill_queue_empty", 32'(exp_q.size()), 32'd0);

        // concurrent push/pop at occupancy 2, 20 cycles
        d = 8'h10;
        step(1'b1, d, 1'b0);
        d++;
        step(1'b1, d, 1'b0);
        d++;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, d, 1'b1);
            d++;
            check("concurrent_count", 32'(count), 32'd2);
        end
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        check("concurrent_queue_empty", 32'(exp_q.size()), 32'd0);

        // mid-stream reset with three beats buffered
        step(1'b1, 8'hE1, 1'b0);
        step(1'b1, 8'hE2, 1'b0);
        step(1'b1, 8'hE3, 1'b0);
        check("pre_reset_count", 32'(count), 32'd3);
        s_valid = 1'b0;
        pulse_reset();
        step(1'b1, 8'h3C, 1'b0);
        check("post_reset_head", 32'(m_data), 32'h3C);
        check("post_reset_count", 32'(count), 32'd1);
        step(1'b0, 8'h00, 1'b1);
        check("post_reset_drained", 32'(exp_q.size()), 32'd0);

        // statistics: 300 beats, peak occupancy 3
        s_valid = 1'b0;
        pulse_reset();
        d = 8'h00;
        repeat (3) begin
            step(1'b1, d, 1'b0);
            d++;
        end
        repeat (297) begin
            step(1'b1, d, 1'b1);
            d++;
        end
        repeat (3) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        check("stats_queue_empty", 32'(exp_q.size()), 32'd0);
`ifdef HANDSHAKE_FIFO_STATS_EN
        check("stats_beats_out", beats_out, 32'd300);
        check("stats_max_count", 32'(max_count), 32'd3);
`else
        check("nostats_beats_out", beats_out, 32'd0);
        check("nostats_max_count", 32'(max_count), 32'd0);
`endif

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
